// File: rtl/parallel_serial_tx.sv
// Asynchronous character transmitter: start bit, DATA_BITS data bits LSB first, optional even parity, stop bit.
// Define TX_PARITY_EN to insert the even-parity bit between the data bits and the stop bit.
module parallel_serial_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] dataFromCPU,
    input  logic                 send,
    output logic                 toSerial,
    output logic                 busy,
    output logic                 charSent
);

    // state    | meaning
    // S_IDLE   | line high, waiting for send
    // S_START  | driving the start bit (0)
    // S_DATA   | driving shift-register bit 0, LSB first
    // S_PARITY | driving the even-parity bit (TX_PARITY_EN only)
    // S_STOP   | driving the stop bit (1); charSent on its last cycle

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_PRE  = CW'(CLKS_PER_BIT - 2);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

`ifdef TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_STOP
    } state_t;
`endif

    state_t               r_state;
    logic [CW-1:0]        r_cnt;
    logic [IW-1:0]        r_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_tx;
    logic                 r_busy;
    logic                 r_char_sent;
`ifdef TX_PARITY_EN
    logic                 r_parity;
`endif

    logic                 w_bit_end;
    logic [DATA_BITS-1:0] w_shift_next;

    assign w_bit_end    = (r_cnt == CNT_LAST);
    assign w_shift_next = r_shift >> 1;

    assign toSerial = r_tx;
    assign busy     = r_busy;
    assign charSent = r_char_sent;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_shift     <= '0;
            r_tx        <= 1'b1;
            r_busy      <= 1'b0;
            r_char_sent <= 1'b0;
`ifdef TX_PARITY_EN
            r_parity    <= 1'b0;
`endif
        end else begin
            r_char_sent <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_tx <= 1'b1;
                    if (send) begin
                        r_shift <= dataFromCPU;
`ifdef TX_PARITY_EN
                        r_parity <= ^dataFromCPU;
`endif
                        r_state <= S_START;
                        r_tx    <= 1'b0;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                        r_idx   <= '0;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_idx   <= '0;
                        r_state <= S_DATA;
                        r_tx    <= r_shift[0];
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_shift <= w_shift_next;
                        if (r_idx == IDX_LAST) begin
`ifdef TX_PARITY_EN
                            r_state <= S_PARITY;
                            r_tx    <= r_parity;
`else
                            r_state <= S_STOP;
                            r_tx    <= 1'b1;
`endif
                        end else begin
                            r_idx <= r_idx + IW'(1);
                            r_tx  <= w_shift_next[0];
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
`ifdef TX_PARITY_EN
                S_PARITY: begin
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_state <= S_STOP;
                        r_tx    <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
`endif
                S_STOP: begin
                    // charSent is raised one edge early so it coincides with the last stop-bit cycle
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                        if (r_cnt == CNT_PRE) begin
                            r_char_sent <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_parallel_serial_tx.sv
// Bench for parallel_serial_tx: per-cycle frame model plus a mid-bit sampling receiver model.
// Define TX_PARITY_EN here as well as in the RTL to exercise the parity build.
module tb_parallel_serial_tx;

    localparam int CPB = 16;
    localparam int DB  = 8;
`ifdef TX_PARITY_EN
    localparam int FB = DB + 3;
`else
    localparam int FB = DB + 2;
`endif
    localparam int FL = FB * CPB;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          send = 1'b0;
    logic [DB-1:0] dataFromCPU = '0;
    logic          toSerial;
    logic          busy;
    logic          charSent;

    int errors = 0;
    int checks = 0;

    bit line_q[$];
    bit busy_q[$];
    bit cs_q[$];
    int rx_chars[$];
    int rx_errs;

    always #5 clk = ~clk;

    parallel_serial_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
        .clk(clk),
        .reset(reset),
        .dataFromCPU(dataFromCPU),
        .send(send),
        .toSerial(toSerial),
        .busy(busy),
        .charSent(charSent)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic sample_cycle();
        @(negedge clk);
        line_q.push_back(toSerial);
        busy_q.push_back(busy);
        cs_q.push_back(charSent);
    endtask

    function automatic void clear_rec();
        line_q.delete();
        busy_q.delete();
        cs_q.delete();
    endfunction

    // Frame bit b of character d: start, data LSB first, optional even parity, stop
    function automatic bit frame_bit(input logic [DB-1:0] d, input int b);
        if (b == 0) return 1'b0;
        if (b <= DB) return d[b-1];
`ifdef TX_PARITY_EN
        if (b == DB + 1) return ^d;
`endif
        return 1'b1;
    endfunction

    // Receiver model: find falling edge from idle, sample every bit at its middle
    function automatic void decode();
        int i;
        rx_chars.delete();
        rx_errs = 0;
        i = 1;
        while (i < line_q.size()) begin
            if (line_q[i-1] && !line_q[i]) begin
                int v;
                bit ok;
                v  = 0;
                ok = 1'b1;
                for (int b = 0; b < FB; b++) begin
                    int p;
                    p = i + CPB / 2 + b * CPB;
                    if (p >= line_q.size()) begin
                        ok = 1'b0;
                        break;
                    end
                    if (b >= 1 && b <= DB) v = v | (int'(line_q[p]) << (b - 1));
                    else if (line_q[p] !== frame_bit(DB'(v), b)) ok = 1'b0;
                end
                if (ok) rx_chars.push_back(v);
                else rx_errs++;
                i = i + (FB - 1) * CPB + CPB / 2;
            end else begin
                i++;
            end
        end
    endfunction

    function automatic int n_busy();
        int n = 0;
        foreach (busy_q[i]) if (busy_q[i]) n++;
        return n;
    endfunction

    function automatic int n_cs();
        int n = 0;
        foreach (cs_q[i]) if (cs_q[i]) n++;
        return n;
    endfunction

    function automatic int cs_index(input int nth);
        int n = 0;
        foreach (cs_q[i]) begin
            if (cs_q[i]) begin
                if (n == nth) return i;
                n++;
            end
        end
        return -1;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        send  = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            checks += 3;
            if (toSerial !== 1'b1) begin errors++; $display("FAIL reset_line cyc %0d: got %b want 1", i, toSerial); end
            if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy cyc %0d: got %b want 0", i, busy); end
            if (charSent !== 1'b0) begin errors++; $display("FAIL reset_charsent cyc %0d: got %b want 0", i, charSent); end
        end
    endtask

    task automatic test_send_with_reset();
        @(negedge clk);
        reset = 1'b1;
        send = 1'b1;
        dataFromCPU = 8'hAA;
        @(negedge clk);
        reset = 1'b0;
        send = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks += 2;
            if (busy !== 1'b0) begin errors++; $display("FAIL send_reset_busy cyc %0d: got %b want 0", i, busy); end
            if (toSerial !== 1'b1) begin errors++; $display("FAIL send_reset_line cyc %0d: got %b want 1", i, toSerial); end
            @(negedge clk);
        end
    endtask

    task automatic test_frame(input logic [DB-1:0] d, input string name);
        clear_rec();
        sample_cycle();
        dataFromCPU = d;
        send = 1'b1;
        sample_cycle();
        send = 1'b0;
        for (int i = 0; i < FL + 10; i++) begin
            dataFromCPU = DB'($urandom);
            sample_cycle();
        end
        // sample 1 is the first start-bit cycle
        for (int i = 0; i < line_q.size(); i++) begin
            int k;
            bit el, eb, ec;
            k  = i - 1;
            el = (k >= 0 && k < FL) ? frame_bit(d, k / CPB) : 1'b1;
            eb = (k >= 0 && k < FL);
            ec = (k == FL - 1);
            checks += 3;
            if (line_q[i] !== el) begin errors++; $display("FAIL %s_line cyc %0d: got %b want %b", name, k, line_q[i], el); end
            if (busy_q[i] !== eb) begin errors++; $display("FAIL %s_busy cyc %0d: got %b want %b", name, k, busy_q[i], eb); end
            if (cs_q[i] !== ec) begin errors++; $display("FAIL %s_charsent cyc %0d: got %b want %b", name, k, cs_q[i], ec); end
        end
        decode();
        checks += 2;
        if (rx_chars.size() !== 1 || rx_errs !== 0) begin
            errors++; $display("FAIL %s_rx_count: got %0d chars %0d errs want 1 chars 0 errs", name, rx_chars.size(), rx_errs);
        end else if (rx_chars[0] !== int'(d)) begin
            errors++; $display("FAIL %s_rx_data: got %h want %h", name, rx_chars[0], d);
        end
        if (n_busy() !== FL) begin errors++; $display("FAIL %s_busy_len: got %0d want %0d", name, n_busy(), FL); end
    endtask

    task automatic test_ignore_busy();
        clear_rec();
        sample_cycle();
        dataFromCPU = 8'h3C;
        send = 1'b1;
        sample_cycle();
        for (int i = 1; i < FL + 20; i++) begin
            if (i < FL - 1 && i % 7 == 0) begin
                send = 1'b1;
                dataFromCPU = 8'hFF;
            end else begin
                send = 1'b0;
                dataFromCPU = DB'($urandom);
            end
            sample_cycle();
        end
        send = 1'b0;
        decode();
        checks += 4;
        if (rx_chars.size() !== 1 || rx_errs !== 0) begin
            errors++; $display("FAIL ignore_rx_count: got %0d chars %0d errs want 1 chars 0 errs", rx_chars.size(), rx_errs);
        end else if (rx_chars[0] !== 32'h3C) begin
            errors++; $display("FAIL ignore_rx_data: got %h want 3c", rx_chars[0]);
        end
        if (n_cs() !== 1) begin errors++; $display("FAIL ignore_charsent_count: got %0d want 1", n_cs()); end
        if (n_busy() !== FL) begin errors++; $display("FAIL ignore_busy_len: got %0d want %0d", n_busy(), FL); end
        if (cs_index(0) !== FL) begin errors++; $display("FAIL ignore_charsent_pos: got %0d want %0d", cs_index(0), FL); end
    endtask

    task automatic test_back_to_back();
        clear_rec();
        sample_cycle();
        dataFromCPU = 8'h00;
        send = 1'b1;
        sample_cycle();
        dataFromCPU = 8'h81;
        for (int i = 2; i <= FL + 2; i++) sample_cycle();
        send = 1'b0;
        for (int i = 0; i < FL + 20; i++) begin
            dataFromCPU = DB'($urandom);
            sample_cycle();
        end
        decode();
        checks += 7;
        if (rx_chars.size() !== 2 || rx_errs !== 0) begin
            errors++; $display("FAIL b2b_rx_count: got %0d chars %0d errs want 2 chars 0 errs", rx_chars.size(), rx_errs);
        end else if (rx_chars[0] !== 32'h00 || rx_chars[1] !== 32'h81) begin
            errors++; $display("FAIL b2b_rx_data: got %h %h want 00 81", rx_chars[0], rx_chars[1]);
        end
        if (n_cs() !== 2) begin errors++; $display("FAIL b2b_charsent_count: got %0d want 2", n_cs()); end
        if (cs_index(0) !== FL) begin errors++; $display("FAIL b2b_charsent0_pos: got %0d want %0d", cs_index(0), FL); end
        if (cs_index(1) !== 2 * FL + 1) begin errors++; $display("FAIL b2b_charsent1_pos: got %0d want %0d", cs_index(1), 2 * FL + 1); end
        if (line_q[FL+1] !== 1'b1 || busy_q[FL+1] !== 1'b0) begin
            errors++; $display("FAIL b2b_gap_idle: got line %b busy %b want line 1 busy 0", line_q[FL+1], busy_q[FL+1]);
        end
        if (line_q[FL+2] !== 1'b0) begin errors++; $display("FAIL b2b_second_start: got %b want 0", line_q[FL+2]); end
        if (n_busy() !== 2 * FL) begin errors++; $display("FAIL b2b_busy_len: got %0d want %0d", n_busy(), 2 * FL); end
    endtask

    task automatic test_reset_mid();
        int rst_at;
        clear_rec();
        sample_cycle();
        dataFromCPU = 8'h55;
        send = 1'b1;
        sample_cycle();
        send = 1'b0;
        rst_at = 1 + 5 * CPB + 3;
        for (int i = 2; i <= rst_at; i++) sample_cycle();
        checks++;
        if (busy_q[rst_at] !== 1'b1) begin errors++; $display("FAIL midrst_busy_before: got %b want 1", busy_q[rst_at]); end
        reset = 1'b1;
        sample_cycle();
        reset = 1'b0;
        checks += 3;
        if (line_q[rst_at+1] !== 1'b1) begin errors++; $display("FAIL midrst_line: got %b want 1", line_q[rst_at+1]); end
        if (busy_q[rst_at+1] !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy_q[rst_at+1]); end
        if (cs_q[rst_at+1] !== 1'b0) begin errors++; $display("FAIL midrst_charsent: got %b want 0", cs_q[rst_at+1]); end
        for (int i = 0; i < FL; i++) sample_cycle();
        checks += 2;
        if (n_cs() !== 0) begin errors++; $display("FAIL midrst_no_charsent: got %0d pulses want 0", n_cs()); end
        if (n_busy() !== rst_at) begin errors++; $display("FAIL midrst_busy_len: got %0d want %0d", n_busy(), rst_at); end
        test_frame(8'h0F, "after_reset");
    endtask

    task automatic test_random();
        int sent[$];
        int t;
        int n;
        n = 6;
        clear_rec();
        sample_cycle();
        for (int f = 0; f < n; f++) begin
            logic [DB-1:0] d;
            d = DB'($urandom);
            repeat ($urandom_range(0, 12)) sample_cycle();
            dataFromCPU = d;
            send = 1'b1;
            sent.push_back(int'(d));
            sample_cycle();
            send = 1'b0;
            t = 0;
            while (busy === 1'b1 && t < FL + 10) begin
                dataFromCPU = DB'($urandom);
                sample_cycle();
                t++;
            end
            checks++;
            if (t >= FL + 10) begin errors++; $display("FAIL rand_busy_timeout frame %0d: busy still %b after %0d cycles", f, busy, t); end
        end
        repeat (10) sample_cycle();
        decode();
        checks += 3;
        if (rx_chars.size() !== n || rx_errs !== 0) begin
            errors++; $display("FAIL rand_rx_count: got %0d chars %0d errs want %0d chars 0 errs", rx_chars.size(), rx_errs, n);
        end else begin
            for (int i = 0; i < n; i++) begin
                checks++;
                if (rx_chars[i] !== sent[i]) begin errors++; $display("FAIL rand_rx_data %0d: got %h want %h", i, rx_chars[i], sent[i]); end
            end
        end
        if (n_cs() !== n) begin errors++; $display("FAIL rand_charsent_count: got %0d want %0d", n_cs(), n); end
        if (n_busy() !== n * FL) begin errors++; $display("FAIL rand_busy_len: got %0d want %0d", n_busy(), n * FL); end
    endtask

`ifdef TX_PARITY_EN
    task automatic test_parity();
        int p;
        clear_rec();
        sample_cycle();
        dataFromCPU = 8'h07;
        send = 1'b1;
        sample_cycle();
        send = 1'b0;
        for (int i = 0; i < FL + 10; i++) sample_cycle();
        p = 1 + (DB + 1) * CPB + CPB / 2;
        decode();
        checks += 3;
        if (line_q[p] !== 1'b1) begin errors++; $display("FAIL parity_bit: got %b want 1", line_q[p]); end
        if (n_busy() !== 11 * CPB) begin errors++; $display("FAIL parity_frame_len: got %0d want %0d", n_busy(), 11 * CPB); end
        if (rx_chars.size() !== 1 || rx_errs !== 0 || rx_chars[0] !== 32'h07) begin
            errors++; $display("FAIL parity_rx: got %0d chars %0d errs want one char 07", rx_chars.size(), rx_errs);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_send_with_reset();
        test_frame(8'hA5, "frame_a5");
        test_ignore_busy();
        test_back_to_back();
        test_reset_mid();
        test_random();
`ifdef TX_PARITY_EN
        test_parity();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
